// File: rtl/float_sort_seq.sv
// Batch sorter for FP64 values: loads N values, bubble-sorts them with one shared comparator, and streams them out smallest first.
// Optional macro FLOAT_SORT_EARLY_EXIT_EN ends the sort after the first pass that performs no swap.

module f_less_or_equal #(
   parameter int FLEN  = 64,
   parameter int EXP_W = 11
) (
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            res,
   output logic            err
);
   localparam int MAN_W = FLEN - 1 - EXP_W;

   logic a_nan;
   logic b_nan;
   logic both_zero;
   logic mag_le;
   logic mag_ge;
   logic ordered_le;

   assign a_nan     = (&a[FLEN-2:MAN_W]) && (|a[MAN_W-1:0]);
   assign b_nan     = (&b[FLEN-2:MAN_W]) && (|b[MAN_W-1:0]);
   assign both_zero = ~|{a[FLEN-2:0], b[FLEN-2:0]};
   assign mag_le    = a[FLEN-2:0] <= b[FLEN-2:0];
   assign mag_ge    = a[FLEN-2:0] >= b[FLEN-2:0];

   // Sign-magnitude ordering; the two zeros compare equal.
   always_comb begin
      ordered_le = 1'b0;
      if (both_zero) begin
         ordered_le = 1'b1;
      end else begin
         case ({a[FLEN-1], b[FLEN-1]})
            2'b00:   ordered_le = mag_le;
            2'b01:   ordered_le = 1'b0;
            2'b10:   ordered_le = 1'b1;
            default: ordered_le = mag_ge;
         endcase
      end
   end

   assign err = a_nan | b_nan;
   assign res = ~err & ordered_le;
endmodule

module float_sort_seq #(
   parameter  int N    = 4,
   localparam int FLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            up_valid,
   input  logic [FLEN-1:0] up_data,
   output logic            up_ready,
   output logic            down_valid,
   output logic [FLEN-1:0] down_data,
   output logic            down_last,
   input  logic            down_ready,
   output logic            err,
   output logic            busy
);
   localparam int CW = $clog2(N) + 1;
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

   state_t          state_reg;
   logic [CW-1:0]   wr_cnt_reg;
   logic [CW-1:0]   rd_cnt_reg;
   logic [CW-1:0]   pass_reg;
   logic [CW-1:0]   j_reg;
   logic            err_reg;
   logic            down_valid_reg;
   logic            down_last_reg;
   logic            busy_reg;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
   logic            swapped_reg;
`endif

   logic [FLEN-1:0] val_mem [N];

   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   rd_idx;
   logic [IW-1:0]   j_idx;
   logic [IW-1:0]   j_nxt;
   logic [CW-1:0]   j_last;
   logic [FLEN-1:0] cmp_a;
   logic [FLEN-1:0] cmp_b;
   logic            cmp_res;
   logic            cmp_err;
   logic            load_en;
   logic            swap_en;
   logic            pass_done;
   logic            sort_done;

   assign wr_idx = wr_cnt_reg[IW-1:0];
   assign rd_idx = rd_cnt_reg[IW-1:0];
   assign j_idx  = j_reg[IW-1:0];
   assign j_nxt  = j_idx + 1'b1;
   assign j_last = CW'(N - 2) - pass_reg;

   assign cmp_a = val_mem[j_idx];
   assign cmp_b = val_mem[j_nxt];

   f_less_or_equal #(.FLEN(FLEN), .EXP_W(11)) u_cmp (
      .a   (cmp_a),
      .b   (cmp_b),
      .res (cmp_res),
      .err (cmp_err)
   );

   assign load_en   = (state_reg == LOAD) && up_valid;
   assign swap_en   = (state_reg == SORT) && !cmp_res;
   assign pass_done = (state_reg == SORT) && (j_reg == j_last);

`ifdef FLOAT_SORT_EARLY_EXIT_EN
   // A pass with no swap anywhere proves the buffer is already ordered.
   assign sort_done = pass_done && ((pass_reg == CW'(N - 2)) || !(swapped_reg || swap_en));
`else
   assign sort_done = pass_done && (pass_reg == CW'(N - 2));
`endif

   // Buffer has no reset; its contents are only observed after a full load.
   always_ff @(posedge clk) begin
      if (load_en) begin
         val_mem[wr_idx] <= up_data;
      end else if (swap_en) begin
         val_mem[j_idx] <= cmp_b;
         val_mem[j_nxt] <= cmp_a;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= LOAD;
         wr_cnt_reg     <= '0;
         rd_cnt_reg     <= '0;
         pass_reg       <= '0;
         j_reg          <= '0;
         err_reg        <= 1'b0;
         down_valid_reg <= 1'b0;
         down_last_reg  <= 1'b0;
         busy_reg       <= 1'b0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
         swapped_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            LOAD: begin
               if (up_valid) begin
                  if (wr_cnt_reg == CW'(N - 1)) begin
                     state_reg   <= SORT;
                     wr_cnt_reg  <= '0;
                     pass_reg    <= '0;
                     j_reg       <= '0;
                     busy_reg    <= 1'b1;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
                     swapped_reg <= 1'b0;
`endif
                  end else begin
                     wr_cnt_reg <= wr_cnt_reg + 1'b1;
                  end
               end
            end
            SORT: begin
               err_reg <= err_reg | cmp_err;
               if (pass_done) begin
                  pass_reg    <= pass_reg + 1'b1;
                  j_reg       <= '0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
                  swapped_reg <= 1'b0;
`endif
                  if (sort_done) begin
                     state_reg      <= OUT;
                     rd_cnt_reg     <= '0;
                     down_valid_reg <= 1'b1;
                     down_last_reg  <= 1'b0;
                  end
               end else begin
                  j_reg <= j_reg + 1'b1;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
                  if (swap_en) begin
                     swapped_reg <= 1'b1;
                  end
`endif
               end
            end
            OUT: begin
               if (down_ready) begin
                  if (down_last_reg) begin
                     state_reg      <= LOAD;
                     rd_cnt_reg     <= '0;
                     down_valid_reg <= 1'b0;
                     down_last_reg  <= 1'b0;
                     busy_reg       <= 1'b0;
                     err_reg        <= 1'b0;
                  end else begin
                     rd_cnt_reg    <= rd_cnt_reg + 1'b1;
                     down_last_reg <= (rd_cnt_reg + 1'b1) == CW'(N - 1);
                  end
               end
            end
            default: state_reg <= LOAD;
         endcase
      end
   end

   // Gated by the reset pin so up_ready drops the moment reset asserts.
   assign up_ready   = rst && (state_reg == LOAD);
   assign down_valid = down_valid_reg;
   assign down_data  = down_valid_reg ? val_mem[rd_idx] : '0;
   assign down_last  = down_last_reg;
   assign err        = err_reg;
   assign busy       = busy_reg;
endmodule

// File: tb/tb_float_sort_seq.sv
// Self-checking bench for float_sort_seq (N=4, FP64): directed cases plus random batches against a real-valued sort model.
module tb_float_sort_seq;
   localparam int N = 4;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef logic [63:0] batch_t [N];

   logic        clk = 1'b0;
   logic        rst;
   logic        up_valid;
   logic [63:0] up_data;
   logic        up_ready;
   logic        down_valid;
   logic [63:0] down_data;
   logic        down_last;
   logic        down_ready;
   logic        err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int n_batch = 0;

   float_sort_seq #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_last  (down_last),
      .down_ready (down_ready),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_nan(input logic [63:0] v);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
   endfunction

   function automatic bit fle(input logic [63:0] a, input logic [63:0] b);
      if (is_nan(a) || is_nan(b)) return 1'b0;
      return $bitstoreal(a) <= $bitstoreal(b);
   endfunction

   // Textbook bubble sort on real values; also reports comparison count and NaN exposure.
   function automatic void model(input batch_t in, output batch_t out, output int cyc, output bit e);
      logic [63:0] t;
      bit sw;
      out = in;
      cyc = 0;
      e   = 1'b0;
      for (int p = 0; p < N - 1; p++) begin
         sw = 1'b0;
         for (int j = 0; j < N - 1 - p; j++) begin
            cyc++;
            if (is_nan(out[j]) || is_nan(out[j+1])) e = 1'b1;
            if (!fle(out[j], out[j+1])) begin
               t = out[j]; out[j] = out[j+1]; out[j+1] = t;
               sw = 1'b1;
            end
         end
         if (EARLY && !sw) break;
      end
   endfunction

   function automatic logic [63:0] rand_val(input bit allow_nan);
      logic [63:0] r;
      case ($urandom_range(0, 11))
         0:       r = 64'h0000_0000_0000_0000;
         1:       r = 64'h8000_0000_0000_0000;
         2:       r = 64'h7FF0_0000_0000_0000;
         3:       r = 64'hFFF0_0000_0000_0000;
         4:       r = allow_nan ? 64'h7FF8_0000_0000_0001 : 64'h3FF0_0000_0000_0000;
         default: r = $realtobits((real'($urandom_range(0, 40)) - 20.0) * 0.25);
      endcase
      return r;
   endfunction

   task automatic load(input batch_t in, input bit hold);
      int t;
      for (int i = 0; i < N; i++) begin
         up_valid = 1'b1;
         up_data  = in[i];
         t = 0;
         while (!up_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("up_ready_load", up_ready, 1);
         @(negedge clk);
      end
      if (hold) up_data = 64'hDEAD_BEEF_0BAD_F00D;
      else      up_valid = 1'b0;
   endtask

   task automatic drain(input batch_t exp, input bit exp_err, input int mode);
      int k = 0;
      int t = 0;
      int ph = 0;
      bit dr;
      bit stall = 1'b0;
      logic [63:0] pd;
      logic pl, pe;
      while (k < N && t < 200) begin
         if (down_valid) begin
            chk("down_data", down_data, exp[k]);
            chk("down_last", down_last, 64'(k == N - 1));
            chk("err_out", err, 64'(exp_err));
            chk("up_ready_out", up_ready, 0);
            if (stall) begin
               chk("hold_data", down_data, pd);
               chk("hold_last", down_last, pl);
               chk("hold_err", err, pe);
            end
         end
         case (mode)
            0:       dr = 1'b1;
            1:       dr = (ph % 3) == 0;
            default: dr = 1'($urandom_range(0, 1));
         endcase
         ph++;
         down_ready = dr;
         stall = down_valid && !dr;
         pd = down_data;
         pl = down_last;
         pe = err;
         if (down_valid && dr) begin
            $display("[TB] batch %0d out %0d data=%h last=%0b err=%0b", n_batch, k, down_data, down_last, err);
            k++;
         end
         @(negedge clk);
         t++;
      end
      chk("handshakes", k, N);
      chk("dv_after", down_valid, 0);
      chk("up_ready_after", up_ready, 1);
   endtask

   task automatic run_batch(input batch_t in, input int mode, input bit hold);
      batch_t exp;
      int cyc, cnt, t;
      bit e;
      model(in, exp, cyc, e);
      n_batch++;
      load(in, hold);
      cnt = 0;
      t = 0;
      while (!down_valid && t < 300) begin
         if (busy) cnt++;
         chk("up_ready_sort", up_ready, 0);
         @(negedge clk);
         t++;
      end
      chk("sort_cycles", cnt, cyc);
      drain(exp, e, mode);
   endtask

   initial begin
      batch_t b_mix, b_sorted, b_nan, b_rand;
      b_mix    = '{64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                   64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000};
      b_sorted = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                   64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000};
      b_nan    = '{64'h4000_0000_0000_0000, 64'h7FF8_0000_0000_0000,
                   64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000};

      rst = 1'b0;
      up_valid = 1'b0;
      up_data = '0;
      down_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_up_ready", up_ready, 0);
      chk("rst_down_valid", down_valid, 0);
      chk("rst_down_last", down_last, 0);
      chk("rst_down_data", down_data, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      #1 chk("release_up_ready", up_ready, 1);
      @(negedge clk);

      run_batch(b_mix, 0, 1'b0);
      run_batch(b_sorted, 0, 1'b0);
      run_batch(b_mix, 1, 1'b0);
      run_batch(b_nan, 0, 1'b0);
      run_batch(b_mix, 0, 1'b0);

      // Abort during the third SORT cycle.
      load(b_mix, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("abort_up_ready", up_ready, 0);
      chk("abort_down_valid", down_valid, 0);
      chk("abort_down_last", down_last, 0);
      chk("abort_down_data", down_data, 0);
      chk("abort_err", err, 0);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      chk("abort_hold_valid", down_valid, 0);
      rst = 1'b1;
      #1 chk("abort_release_ready", up_ready, 1);
      @(negedge clk);
      run_batch(b_sorted, 0, 1'b0);

      // Back-to-back batches with up_valid never dropped.
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < N; k++) b_rand[k] = rand_val(1'b0);
         run_batch(b_rand, 0, 1'b1);
      end
      up_valid = 1'b0;

      for (int i = 0; i < 25; i++) begin
         for (int k = 0; k < N; k++) b_rand[k] = rand_val(i % 4 == 3);
         run_batch(b_rand, 2, 1'(i % 2));
      end
      up_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
